// File: rtl/uart_pkg.sv
// Shared types and helpers for the tt_um_uart_top UART slice.
// Parity support is compiled in when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVS_DEFAULT = 16;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Field order matches ui_in[7:3].
  typedef struct packed {
    logic       stop2;
    logic       par_dis;
    logic       par_odd;
    logic [1:0] len;
  } uart_cfg_t;

  // Index of the last data bit: 00 -> 4 (5 bits) ... 11 -> 7 (8 bits).
  function automatic logic [2:0] data_last(input logic [1:0] len);
    return {1'b1, len};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] len);
    return 8'hFF >> (2'd3 - len);
  endfunction

endpackage

// File: rtl/uart_if.sv
// Core-side UART bundle: conditioned strobes and config in, line and status out.
interface uart_if;
  logic                 rx;
  logic                 start;
  logic                 tick;
  uart_pkg::uart_cfg_t  cfg;
  logic [7:0]           tx_data;
  logic                 tx;
  logic                 tx_busy;
  logic                 rx_ready;
  logic                 rx_error;
  logic [7:0]           rx_data;

  modport master (
    output rx, start, tick, cfg, tx_data,
    input  tx, tx_busy, rx_ready, rx_error, rx_data
  );

  modport slave (
    input  rx, start, tick, cfg, tx_data,
    output tx, tx_busy, rx_ready, rx_error, rx_data
  );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART engine: independent TX and RX FSMs advanced by an oversample tick.
// Parity generation/check exists only when UART_PARITY_EN is defined.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned OVS = OVS_DEFAULT
) (
  input logic   clk,
  input logic   rst_n,
  uart_if.slave bus
);

  localparam int unsigned   CW       = $clog2(OVS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);

  logic cfg_par_en;
`ifdef UART_PARITY_EN
  assign cfg_par_en = !bus.cfg.par_dis;
`else
  logic unused_par_cfg;
  assign cfg_par_en     = 1'b0;
  assign unused_par_cfg = &{1'b0, bus.cfg.par_dis};
`endif

  tx_state_t     tx_state;
  logic [CW-1:0] tx_tcnt;
  logic [2:0]    tx_bit;
  logic [2:0]    tx_last;
  logic [7:0]    tx_shift;
  logic          tx_par_bit;
  logic          tx_par_en;
  logic          tx_stop2;
  logic          tx_stop_cnt;
  logic          tx_q;
  logic          tx_busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_tcnt     <= '0;
      tx_bit      <= '0;
      tx_last     <= '0;
      tx_shift    <= '0;
      tx_par_bit  <= 1'b0;
      tx_par_en   <= 1'b0;
      tx_stop2    <= 1'b0;
      tx_stop_cnt <= 1'b0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      tx_q <= 1'b1;
      if (bus.start) begin
        tx_shift   <= bus.tx_data & data_mask(bus.cfg.len);
        tx_last    <= data_last(bus.cfg.len);
        tx_par_bit <= (^(bus.tx_data & data_mask(bus.cfg.len))) ^ bus.cfg.par_odd;
        tx_par_en  <= cfg_par_en;
        tx_stop2   <= bus.cfg.stop2;
        tx_tcnt    <= '0;
        tx_q       <= 1'b0;
        tx_busy_q  <= 1'b1;
        tx_state   <= TX_START;
      end
    end else if (bus.tick) begin
      if (tx_tcnt != CNT_LAST) begin
        tx_tcnt <= tx_tcnt + 1'b1;
      end else begin
        tx_tcnt <= '0;
        case (tx_state)
          TX_START: begin
            tx_bit   <= '0;
            tx_q     <= tx_shift[0];
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit == tx_last) begin
              tx_stop_cnt <= 1'b0;
              if (tx_par_en) begin
                tx_q     <= tx_par_bit;
                tx_state <= TX_PARITY;
              end else begin
                tx_q     <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= tx_shift >> 1;
              tx_q     <= tx_shift[1];
            end
          end
          TX_PARITY: begin
            tx_q     <= 1'b1;
            tx_state <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_stop2 && !tx_stop_cnt) begin
              tx_stop_cnt <= 1'b1;
            end else begin
              tx_busy_q <= 1'b0;
              tx_state  <= TX_IDLE;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  rx_state_t     rx_state;
  logic [CW-1:0] rx_tcnt;
  logic [2:0]    rx_bit;
  logic [2:0]    rx_last;
  logic [7:0]    rx_shift;
  logic          rx_par_acc;
  logic          rx_par_odd;
  logic          rx_par_en;
  logic          rx_prev;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          rx_error;

  // Parity accumulator is seeded with the odd flag, so after folding in the
  // data and parity bits a nonzero value means a mismatch for either sense.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_tcnt    <= '0;
      rx_bit     <= '0;
      rx_last    <= '0;
      rx_shift   <= '0;
      rx_par_acc <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_en  <= 1'b0;
      rx_prev    <= 1'b1;
      rx_data    <= '0;
      rx_ready   <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      rx_prev <= bus.rx;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !bus.rx) begin
            rx_tcnt    <= '0;
            rx_last    <= data_last(bus.cfg.len);
            rx_par_odd <= bus.cfg.par_odd;
            rx_par_en  <= cfg_par_en;
            rx_state   <= RX_START;
          end
        end
        RX_START: begin
          if (bus.tick) begin
            if (rx_tcnt != CNT_MID) begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end else begin
              rx_tcnt <= '0;
              if (!bus.rx) begin
                rx_ready   <= 1'b0;
                rx_error   <= 1'b0;
                rx_shift   <= '0;
                rx_bit     <= '0;
                rx_par_acc <= rx_par_odd;
                rx_state   <= RX_DATA;
              end else begin
                rx_state <= RX_IDLE;
              end
            end
          end
        end
        RX_DATA: begin
          if (bus.tick) begin
            if (rx_tcnt != CNT_LAST) begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end else begin
              rx_tcnt          <= '0;
              rx_shift[rx_bit] <= bus.rx;
              rx_par_acc       <= rx_par_acc ^ bus.rx;
              if (rx_bit == rx_last) begin
                rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
              end else begin
                rx_bit <= rx_bit + 1'b1;
              end
            end
          end
        end
        RX_PARITY: begin
          if (bus.tick) begin
            if (rx_tcnt != CNT_LAST) begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end else begin
              rx_tcnt    <= '0;
              rx_par_acc <= rx_par_acc ^ bus.rx;
              rx_state   <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (bus.tick) begin
            if (rx_tcnt != CNT_LAST) begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end else begin
              rx_tcnt  <= '0;
              rx_data  <= rx_shift;
              rx_ready <= 1'b1;
              rx_error <= !bus.rx || (rx_par_en && rx_par_acc);
              rx_state <= RX_IDLE;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_busy  = tx_busy_q;
  assign bus.rx_ready = rx_ready;
  assign bus.rx_error = rx_error;
  assign bus.rx_data  = rx_data;

endmodule

// File: rtl/tt_um_uart_top.sv
// Tiny Tapeout pin wrapper: input synchronisers, tick/start edge detects, pin mapping.
// Build with UART_PARITY_EN defined to enable parity framing.
module tt_um_uart_top
  import uart_pkg::*;
#(
  parameter int unsigned OVS      = OVS_DEFAULT,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [2:0] sync_q [SYNC_STG];
  logic [2:0] synced;
  logic       tick_prev;
  logic       start_prev;

  // The rx stage resets high so a reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STG; i++) begin
        sync_q[i] <= 3'b001;
      end
      tick_prev  <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      sync_q[0] <= ui_in[2:0];
      for (int unsigned i = 1; i < SYNC_STG; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      tick_prev  <= synced[2];
      start_prev <= synced[1];
    end
  end

  assign synced = sync_q[SYNC_STG-1];

  uart_if bus ();

  assign bus.rx      = synced[0];
  assign bus.start   = synced[1] && !start_prev;
  assign bus.tick    = synced[2] && !tick_prev;
  assign bus.cfg     = ui_in[7:3];
  assign bus.tx_data = uio_in;

  uart_core #(
    .OVS (OVS)
  ) uart_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign uo_out  = {bus.rx_data[3:0], bus.rx_error, bus.rx_ready, bus.tx_busy, bus.tx};
  assign uio_out = '0;
  assign uio_oe  = '0;

  logic unused_top;
  assign unused_top = &{1'b0, ena, bus.rx_data[7:4]};

endmodule

// File: tb/tb_tt_um_uart_top.sv
// Directed scoreboard bench for tt_um_uart_top; parity cases follow UART_PARITY_EN.
module tb_tt_um_uart_top;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  logic       tx_exp [$];
  logic [8:0] rx_exp [$];

  uart_if bus ();

  always #5 clk = ~clk;

  assign ui_in        = {bus.cfg, bus.tick, bus.start, bus.rx};
  assign uio_in       = bus.tx_data;
  assign bus.tx       = uo_out[0];
  assign bus.tx_busy  = uo_out[1];
  assign bus.rx_ready = uo_out[2];
  assign bus.rx_error = uo_out[3];
  assign bus.rx_data  = dut.uart_inst.rx_data;

  tt_um_uart_top #(
    .OVS      (16),
    .SYNC_STG (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One oversample tick: 2 clks high, 2 clks low; starts and ends on a negedge.
  task automatic tick_once();
    bus.tick = 1'b1;
    repeat (2) @(negedge clk);
    bus.tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_once();
  endtask

  function automatic bit par_on(input logic [4:0] c);
`ifdef UART_PARITY_EN
    return !c[3];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbits(input logic [4:0] c);
    return int'(c[1:0]) + 5;
  endfunction

  task automatic tx_frame(input logic [7:0] data, input logic [4:0] cfg, input string tag);
    int   n;
    logic p;
    logic b;
    n = nbits(cfg);
    p = cfg[2];
    tx_exp.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      tx_exp.push_back(data[i]);
      p = p ^ data[i];
    end
    if (par_on(cfg)) tx_exp.push_back(p);
    tx_exp.push_back(1'b1);
    if (cfg[4]) tx_exp.push_back(1'b1);

    bus.cfg     = cfg;
    bus.tx_data = data;
    bus.start   = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_start_tx"}, 32'(bus.tx), 32'(1'b0));
    check({tag, "_start_busy"}, 32'(bus.tx_busy), 32'(1'b1));
    // the frame in flight must not follow these
    bus.cfg     = cfg ^ 5'h1F;
    bus.tx_data = ~data;
    while (tx_exp.size() > 0) begin
      ticks(8);
      b = tx_exp.pop_front();
      check({tag, "_bit"}, 32'(bus.tx), 32'(b));
      check({tag, "_busy"}, 32'(bus.tx_busy), 32'(1'b1));
      ticks(8);
    end
    check({tag, "_done_busy"}, 32'(bus.tx_busy), 32'(1'b0));
    check({tag, "_done_tx"}, 32'(bus.tx), 32'(1'b1));
  endtask

  task automatic rx_frame(input logic [7:0] data, input logic [4:0] cfg, input bit par_flip,
                          input logic stop_val, input string tag);
    int         n;
    logic       p;
    logic       err;
    logic [7:0] m;
    logic [8:0] e;
    n = nbits(cfg);
    m = '0;
    p = cfg[2];
    for (int i = 0; i < n; i++) begin
      m[i] = data[i];
      p    = p ^ data[i];
    end
    p   = p ^ par_flip;
    err = (par_on(cfg) && par_flip) || !stop_val;
    rx_exp.push_back({err, m});

    bus.cfg = cfg;
    bus.rx  = 1'b0;
    ticks(16);
    check({tag, "_ready_clr"}, 32'(bus.rx_ready), 32'(1'b0));
    for (int i = 0; i < n; i++) begin
      bus.rx = data[i];
      ticks(16);
    end
    if (par_on(cfg)) begin
      bus.rx = p;
      ticks(16);
    end
    bus.rx = stop_val;
    ticks(16);
    bus.rx = 1'b1;
    ticks(2);
    e = rx_exp.pop_front();
    check({tag, "_data"}, 32'(bus.rx_data), 32'(e[7:0]));
    check({tag, "_ready"}, 32'(bus.rx_ready), 32'(1'b1));
    check({tag, "_error"}, 32'(bus.rx_error), 32'(e[8]));
    check({tag, "_nibble"}, 32'(uo_out[7:4]), 32'(e[3:0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx      = 1'b1;
    bus.start   = 1'b0;
    bus.tick    = 1'b0;
    bus.cfg     = '0;
    bus.tx_data = '0;
    ena         = 1'b1;
    rst_n       = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_uo_out", 32'(uo_out), 32'h01);
    check("reset_uio_oe", 32'(uio_oe), 32'h00);
    check("reset_uio_out", 32'(uio_out), 32'h00);
    check("reset_rx_data", 32'(bus.rx_data), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);

    tx_frame(8'hA5, 5'b01011, "tx_8n1");
    rx_frame(8'h5A, 5'b01011, 1'b0, 1'b1, "rx_8n1");
    rx_frame(8'hAA, 5'b00111, 1'b1, 1'b1, "rx_odd_bad");
    rx_frame(8'hAA, 5'b00111, 1'b0, 1'b1, "rx_odd_good");
    rx_frame(8'hC3, 5'b01011, 1'b0, 1'b0, "rx_framing");

    bus.rx = 1'b0;
    ticks(4);
    bus.rx = 1'b1;
    ticks(12);
    check("glitch_idle", 32'(dut.uart_inst.rx_state), 32'(RX_IDLE));
    check("glitch_ready", 32'(bus.rx_ready), 32'(1'b1));
    check("glitch_error", 32'(bus.rx_error), 32'(1'b1));
    check("glitch_data", 32'(bus.rx_data), 32'hC3);

    tx_frame(8'h1F, 5'b01000, "tx_5n1");
    tx_frame(8'hA5, 5'b10011, "tx_8e2");
    rx_frame(8'hF3, 5'b00000, 1'b0, 1'b1, "rx_5bit");

    bus.cfg     = 5'b01011;
    bus.tx_data = 8'h00;
    bus.start   = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    bus.rx    = 1'b0;
    ticks(20);
    check("midframe_busy", 32'(bus.tx_busy), 32'(1'b1));
    rst_n = 1'b0;
    @(negedge clk);
    check("midframe_rst_uo_out", 32'(uo_out), 32'h01);
    check("midframe_rst_tx_state", 32'(dut.uart_inst.tx_state), 32'(TX_IDLE));
    check("midframe_rst_rx_state", 32'(dut.uart_inst.rx_state), 32'(RX_IDLE));
    bus.rx = 1'b1;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
